booth_divider: RTL and testbench



---
 rtl/booth_divider.sv | 160 ++++++++++++++++
 tb/tb_booth_divider.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/booth_divider.sv
// Sequential signed divider: 2*WIDTH-bit dividend by WIDTH-bit divisor,
// restoring iterations on magnitudes, fixed 2*WIDTH+2-cycle latency.
module booth_divider #(
  parameter int unsigned WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [2*WIDTH-1:0]   Dividend,
  input  logic [WIDTH-1:0]     Divisor,
  output logic                 busy,
  output logic                 done,
  output logic [WIDTH-1:0]     Quotient,
  output logic [WIDTH-1:0]     Remainder,
  output logic                 overflow,
  output logic                 div_zero
);

  localparam int unsigned DW    = 2 * WIDTH;
  localparam int unsigned CNT_W = $clog2(DW);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DW - 1);
  localparam logic [DW-1:0]    POS_MAX  = DW'((1 << (WIDTH - 1)) - 1);
  localparam logic [DW-1:0]    NEG_MAX  = DW'(1 << (WIDTH - 1));

  typedef enum logic [1:0] {
    S_IDLE,
    S_DIV,
    S_FIX,
    S_DONE
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [DW-1:0]      quo_q, quo_d;
  logic [WIDTH-1:0]   rem_q, rem_d;
  logic [WIDTH-1:0]   dvs_q, dvs_d;
  logic               sd_q, sd_d;
  logic               ss_q, ss_d;
  logic               zero_q, zero_d;
  logic [WIDTH-1:0]   dlo_q, dlo_d;
  logic [WIDTH-1:0]   q_out_q, q_out_d;
  logic [WIDTH-1:0]   r_out_q, r_out_d;
  logic               ovf_q, ovf_d;
  logic               dz_q, dz_d;

  logic [WIDTH:0]     shifted;
  logic               ge;
  logic               neg;
  logic               range_err;

  // Magnitudes are unsigned, so |-2^(DW-1)| still fits in DW bits.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    quo_d     = quo_q;
    rem_d     = rem_q;
    dvs_d     = dvs_q;
    sd_d      = sd_q;
    ss_d      = ss_q;
    zero_d    = zero_q;
    dlo_d     = dlo_q;
    q_out_d   = q_out_q;
    r_out_d   = r_out_q;
    ovf_d     = ovf_q;
    dz_d      = dz_q;
    shifted   = {rem_q, quo_q[DW-1]};
    ge        = (shifted >= {1'b0, dvs_q});
    neg       = sd_q ^ ss_q;
    range_err = neg ? (quo_q > NEG_MAX) : (quo_q > POS_MAX);

    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d = S_DIV;
          cnt_d   = '0;
          quo_d   = Dividend[DW-1] ? (~Dividend + 1'b1) : Dividend;
          rem_d   = '0;
          dvs_d   = Divisor[WIDTH-1] ? (~Divisor + 1'b1) : Divisor;
          sd_d    = Dividend[DW-1];
          ss_d    = Divisor[WIDTH-1];
          zero_d  = (Divisor == '0);
          dlo_d   = Dividend[WIDTH-1:0];
        end else if (state_q == S_DONE) begin
          state_d = S_IDLE;
        end
      end

      S_DIV: begin
        rem_d = ge ? WIDTH'(shifted - {1'b0, dvs_q}) : shifted[WIDTH-1:0];
        quo_d = {quo_q[DW-2:0], ge};
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_LAST) begin
          state_d = S_FIX;
        end
      end

      S_FIX: begin
        state_d = S_DONE;
        if (zero_q) begin
          q_out_d = '0;
          r_out_d = dlo_q;
          ovf_d   = 1'b0;
          dz_d    = 1'b1;
        end else if (range_err) begin
          q_out_d = '0;
          r_out_d = '0;
          ovf_d   = 1'b1;
          dz_d    = 1'b0;
        end else begin
          q_out_d = neg  ? (~quo_q[WIDTH-1:0] + 1'b1) : quo_q[WIDTH-1:0];
          r_out_d = sd_q ? (~rem_q + 1'b1) : rem_q;
          ovf_d   = 1'b0;
          dz_d    = 1'b0;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      quo_q   <= '0;
      rem_q   <= '0;
      dvs_q   <= '0;
      sd_q    <= 1'b0;
      ss_q    <= 1'b0;
      zero_q  <= 1'b0;
      dlo_q   <= '0;
      q_out_q <= '0;
      r_out_q <= '0;
      ovf_q   <= 1'b0;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
      dvs_q   <= dvs_d;
      sd_q    <= sd_d;
      ss_q    <= ss_d;
      zero_q  <= zero_d;
      dlo_q   <= dlo_d;
      q_out_q <= q_out_d;
      r_out_q <= r_out_d;
      ovf_q   <= ovf_d;
      dz_q    <= dz_d;
    end
  end

  assign busy      = (state_q == S_DIV) || (state_q == S_FIX);
  assign done      = (state_q == S_DONE);
  assign Quotient  = q_out_q;
  assign Remainder = r_out_q;
  assign overflow  = ovf_q;
  assign div_zero  = dz_q;

endmodule

// File: tb/tb_booth_divider.sv
// Bench for booth_divider: integer-arithmetic reference model with a
// cycle-latency tracker, compared every cycle, plus directed literal checks.
module tb_booth_divider;

  localparam int LAT = 18;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [15:0] Dividend = '0;
  logic [7:0]  Divisor = '0;
  logic        busy, done, overflow, div_zero;
  logic [7:0]  Quotient, Remainder;

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;

  booth_divider #(.WIDTH(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .Dividend  (Dividend),
    .Divisor   (Divisor),
    .busy      (busy),
    .done      (done),
    .Quotient  (Quotient),
    .Remainder (Remainder),
    .overflow  (overflow),
    .div_zero  (div_zero)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] q;
    logic [7:0] r;
    logic       o;
    logic       z;
  } res_t;

  function automatic res_t model(input logic [15:0] dd, input logic [7:0] dv);
    res_t res;
    int a, b, qi, ri;
    a = $signed(dd);
    b = $signed(dv);
    res = '0;
    if (b == 0) begin
      res.r = dd[7:0];
      res.z = 1'b1;
    end else begin
      qi = a / b;
      ri = a % b;
      if (qi > 127 || qi < -128) begin
        res.o = 1'b1;
      end else begin
        res.q = qi[7:0];
        res.r = ri[7:0];
      end
    end
    return res;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference timing: m_cnt=1 after accepting edge, LAT on the done cycle.
  int   m_cnt = 0;
  res_t pend  = '0;
  res_t exp_r = '0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_cnt <= 0;
      exp_r <= '0;
    end else if ((m_cnt == 0 || m_cnt == LAT) && start) begin
      m_cnt <= 1;
      pend  <= model(Dividend, Divisor);
    end else if (m_cnt == LAT) begin
      m_cnt <= 0;
    end else if (m_cnt > 0) begin
      m_cnt <= m_cnt + 1;
      if (m_cnt + 1 == LAT) exp_r <= pend;
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("busy",      {31'b0, busy},     {31'b0, (m_cnt >= 1 && m_cnt < LAT)});
      chk("done",      {31'b0, done},     {31'b0, (m_cnt == LAT)});
      chk("quotient",  {24'b0, Quotient}, {24'b0, exp_r.q});
      chk("remainder", {24'b0, Remainder},{24'b0, exp_r.r});
      chk("overflow",  {31'b0, overflow}, {31'b0, exp_r.o});
      chk("div_zero",  {31'b0, div_zero}, {31'b0, exp_r.z});
    end
  end

  task automatic start_op(input logic [15:0] dd, input logic [7:0] dv);
    @(negedge clk);
    Dividend = dd;
    Divisor  = dv;
    start    = 1'b1;
    @(negedge clk);
    start    = 1'b0;
  endtask

  // Called on the negedge after the accepting edge; returns edges counted.
  task automatic wait_done(input int pulse_at, output int n);
    n = 1;
    while (!done && n < 40) begin
      if (n == pulse_at) start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      n++;
    end
  endtask

  task automatic check_res(input string name, input int n, input logic [7:0] q,
                           input logic [7:0] r, input logic o, input logic z);
    chk({name, "_latency"}, n, LAT);
    chk({name, "_q"},   {24'b0, Quotient},  {24'b0, q});
    chk({name, "_r"},   {24'b0, Remainder}, {24'b0, r});
    chk({name, "_ovf"}, {31'b0, overflow},  {31'b0, o});
    chk({name, "_dz"},  {31'b0, div_zero},  {31'b0, z});
  endtask

  task automatic op(input string name, input logic [15:0] dd, input logic [7:0] dv,
                    input logic [7:0] q, input logic [7:0] r, input logic o, input logic z);
    int n;
    start_op(dd, dv);
    wait_done(0, n);
    check_res(name, n, q, r, o, z);
  endtask

  initial begin
    int n;
    repeat (3) @(negedge clk);
    cmp_en = 1'b1;
    chk("reset_busy", {31'b0, busy}, 32'd0);
    chk("reset_q",    {24'b0, Quotient}, 32'd0);
    rst_n = 1'b1;

    op("72_9",      16'd72,       8'd9,       8'd8,   8'd0,   1'b0, 1'b0);
    op("m72_9",     -16'sd72,     8'd9,       8'hF8,  8'd0,   1'b0, 1'b0);
    op("100_m7",    16'd100,      -8'sd7,     8'hF2,  8'd2,   1'b0, 1'b0);
    op("m100_7",    -16'sd100,    8'd7,       8'hF2,  8'hFE,  1'b0, 1'b0);
    op("m256_2",    -16'sd256,    8'd2,       8'h80,  8'd0,   1'b0, 1'b0);
    op("256_2",     16'd256,      8'd2,       8'd0,   8'd0,   1'b1, 1'b0);
    op("m32768_m1", 16'h8000,     8'hFF,      8'd0,   8'd0,   1'b1, 1'b0);
    op("16384_2",   16'd16384,    8'd2,       8'd0,   8'd0,   1'b1, 1'b0);
    op("1234_0",    16'd1234,     8'd0,       8'd0,   8'hD2,  1'b0, 1'b1);
    op("127_1",     16'd127,      8'd1,       8'd127, 8'd0,   1'b0, 1'b0);
    op("m32768_m128", 16'h8000,   8'h80,      8'd0,   8'd0,   1'b1, 1'b0);

    // Spurious start mid-operation, then start held in the DONE cycle.
    start_op(16'd72, 8'd9);
    wait_done(5, n);
    check_res("ign_start", n, 8'd8, 8'd0, 1'b0, 1'b0);
    Dividend = 16'd100;
    Divisor  = -8'sd7;
    start    = 1'b1;
    @(negedge clk);
    start    = 1'b0;
    chk("b2b_busy", {31'b0, busy}, 32'd1);
    chk("b2b_hold_q", {24'b0, Quotient}, 32'd8);
    wait_done(0, n);
    check_res("b2b", n, 8'hF2, 8'd2, 1'b0, 1'b0);

    // Asynchronous reset mid-DIV.
    start_op(16'd72, 8'd9);
    repeat (9) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_busy", {31'b0, busy},      32'd0);
    chk("rst_done", {31'b0, done},      32'd0);
    chk("rst_q",    {24'b0, Quotient},  32'd0);
    chk("rst_r",    {24'b0, Remainder}, 32'd0);
    chk("rst_ovf",  {31'b0, overflow},  32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    op("post_rst",  16'd72,       8'd9,       8'd8,   8'd0,   1'b0, 1'b0);

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
